// File: rtl/sr_request_driver_pkg.sv
// Shared types and defaults for the S/R request driver: FSM encoding,
// command select, collision-priority constants and default timing values.
package sr_request_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  typedef enum logic {
    CMD_RST = 1'b0,
    CMD_SET = 1'b1
  } cmd_e;

  localparam int PRIO_RESET_WINS     = 0;
  localparam int PRIO_SET_WINS       = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sr_request_driver_sync_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw request line;
// emits a registered one-cycle event on each debounced rising edge.
module sr_request_driver_sync_debounce
  import sr_request_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic evt_o
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips one cycle after the counter reaches its top value,
  // independent of the synchroniser value in that cycle.
  always_comb begin
    deb_d = deb_q;
    evt_d = 1'b0;
    cnt_d = '0;
    if (cnt_q == CNT_TOP) begin
      deb_d = ~deb_q;
      evt_d = ~deb_q;
    end else if (sync2_q != deb_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/sr_request_driver.sv
// Drives S/R of a downstream SR flip-flop from raw set/reset requests:
// debounced edge events, pending flags, arbitration and a hold-off gap.
module sr_request_driver
  import sr_request_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int PRIO_SET        = PRIO_RESET_WINS,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic collide
);

  localparam logic [CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic             set_evt, rst_evt;
  logic             set_pend_q, set_pend_d;
  logic             rst_pend_q, rst_pend_d;
  state_e           state_q, state_d;
  cmd_e             sel_q, sel_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             s_q, s_d, r_q, r_d;

  sr_request_driver_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_db (
    .clk_i (clk),
    .rst_ni(rst_n),
    .req_i (set_req),
    .evt_o (set_evt)
  );

  sr_request_driver_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rst_db (
    .clk_i (clk),
    .rst_ni(rst_n),
    .req_i (rst_req),
    .evt_o (rst_evt)
  );

  // S/R are registered from the next-state decision so they are high
  // exactly while the FSM sits in ISSUE.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gap_d      = gap_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    collide    = 1'b0;
    set_pend_d = set_pend_q;
    rst_pend_d = rst_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (set_pend_q && rst_pend_q) begin
          collide = 1'b1;
          state_d = ST_ISSUE;
          if (PRIO_SET == PRIO_SET_WINS) begin
            sel_d      = CMD_SET;
            s_d        = 1'b1;
            rst_pend_d = 1'b0;
          end else begin
            sel_d      = CMD_RST;
            r_d        = 1'b1;
            set_pend_d = 1'b0;
          end
        end else if (set_pend_q) begin
          state_d = ST_ISSUE;
          sel_d   = CMD_SET;
          s_d     = 1'b1;
        end else if (rst_pend_q) begin
          state_d = ST_ISSUE;
          sel_d   = CMD_RST;
          r_d     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (sel_q == CMD_SET) set_pend_d = 1'b0;
        else                  rst_pend_d = 1'b0;
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh event always wins over a same-cycle clear.
    if (set_evt) set_pend_d = 1'b1;
    if (rst_evt) rst_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= CMD_RST;
      gap_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gap_q      <= gap_d;
      s_q        <= s_d;
      r_q        <= r_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
    end
  end

  assign S    = s_q;
  assign R    = r_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_request_driver.sv
// Directed bench for sr_request_driver: defaults, set-priority and
// zero-gap instances driven from shared request lines.
module tb_sr_request_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic s0, r0, b0, c0;
  logic s1, r1, b1, c1;
  logic s2, r2, b2, c2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sr_request_driver u_def (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .S(s0), .R(r0), .busy(b0), .collide(c0)
  );

  sr_request_driver #(.PRIO_SET(1)) u_pset (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .S(s1), .R(r1), .busy(b1), .collide(c1)
  );

  sr_request_driver #(.GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .S(s2), .R(r2), .busy(b2), .collide(c2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Output invariants on every instance, sampled mid-cycle.
  logic [2:0] s_v, r_v, c_v, s_p, r_p, c_p;
  assign s_v = {s2, s1, s0};
  assign r_v = {r2, r1, r0};
  assign c_v = {c2, c1, c0};
  initial begin s_p = '0; r_p = '0; c_p = '0; end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("inv_s_and_r_%0d", i), s_v[i] & r_v[i], 1'b0);
        chk($sformatf("inv_s_twice_%0d", i), s_v[i] & s_p[i], 1'b0);
        chk($sformatf("inv_r_twice_%0d", i), r_v[i] & r_p[i], 1'b0);
        chk($sformatf("inv_c_twice_%0d", i), c_v[i] & c_p[i], 1'b0);
      end
    end
    s_p = s_v;
    r_p = r_v;
    c_p = c_v;
  end

  initial begin
    // Reset state, before any clock edge.
    #3;
    chk("rst_S", s0, 1'b0);
    chk("rst_R", r0, 1'b0);
    chk("rst_busy", b0, 1'b0);
    chk("rst_collide", c0, 1'b0);
    chk("rst_S_pset", s1, 1'b0);
    chk("rst_busy_gap0", b2, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Held set request: S in the cycle after edge 8, busy for 3 cycles.
    set_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t1_S_k%0d", k), s0, (k == 8));
      chk($sformatf("t1_R_k%0d", k), r0, 1'b0);
      chk($sformatf("t1_busy_k%0d", k), b0, (k >= 8 && k <= 10));
      chk($sformatf("t1_collide_k%0d", k), c0, 1'b0);
      chk($sformatf("t1_S_gap0_k%0d", k), s2, (k == 8));
      chk($sformatf("t1_busy_gap0_k%0d", k), b2, (k == 8));
    end
    set_req = 1'b0;
    idle(15);

    // Three-cycle glitch is rejected.
    for (int k = 0; k < 23; k++) begin
      set_req = (k < 3);
      tick();
      chk($sformatf("t2_S_k%0d", k), s0, 1'b0);
      chk($sformatf("t2_R_k%0d", k), r0, 1'b0);
      chk($sformatf("t2_busy_k%0d", k), b0, 1'b0);
    end
    idle(5);

    // Simultaneous requests: reset wins on u_def, set wins on u_pset.
    set_req = 1'b1;
    rst_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t3_R_k%0d", k), r0, (k == 8));
      chk($sformatf("t3_S_k%0d", k), s0, 1'b0);
      chk($sformatf("t3_collide_k%0d", k), c0, (k == 7));
      chk($sformatf("t3_S_pset_k%0d", k), s1, (k == 8));
      chk($sformatf("t3_R_pset_k%0d", k), r1, 1'b0);
      chk($sformatf("t3_collide_pset_k%0d", k), c1, (k == 7));
    end
    set_req = 1'b0;
    rst_req = 1'b0;
    idle(15);

    // Reset request landing in HOLDOFF: R four cycles after S.
    set_req = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) rst_req = 1'b1;
      tick();
      chk($sformatf("t4_S_k%0d", k), s0, (k == 8));
      chk($sformatf("t4_R_k%0d", k), r0, (k == 12));
      chk($sformatf("t4_busy_k%0d", k), b0, (k >= 8 && k <= 10) || (k >= 12 && k <= 14));
      chk($sformatf("t4_R_gap0_k%0d", k), r2, (k == 11));
    end
    set_req = 1'b0;
    rst_req = 1'b0;
    idle(15);

    // Zero gap: set then reset events 10 cycles apart.
    set_req = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k == 10) rst_req = 1'b1;
      tick();
      chk($sformatf("t6_S_gap0_k%0d", k), s2, (k == 8));
      chk($sformatf("t6_R_gap0_k%0d", k), r2, (k == 18));
      chk($sformatf("t6_busy_gap0_k%0d", k), b2, (k == 8 || k == 18));
    end
    set_req = 1'b0;
    rst_req = 1'b0;
    idle(15);

    // Reset during ISSUE aborts the pulse at once and nothing replays.
    set_req = 1'b1;
    idle(9);
    chk("t5_S_issue", s0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_S_async", s0, 1'b0);
    chk("t5_busy_async", b0, 1'b0);
    chk("t5_S_pset_async", s1, 1'b0);
    set_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t5_S_k%0d", k), s0, 1'b0);
      chk($sformatf("t5_R_k%0d", k), r0, 1'b0);
      chk($sformatf("t5_busy_k%0d", k), b0, 1'b0);
      chk($sformatf("t5_collide_k%0d", k), c0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sr_request_driver.md
Name: sr_request_driver

Overview:
- Front-end stage that drives the S/R inputs of the downstream SR flip-flop from two raw, asynchronous, possibly bouncing request lines (set_req, rst_req).
- Synchronises and debounces each line, then converts each debounced rising edge into a one-cycle S or R pulse.
- Arbitrates simultaneous requests and enforces a hold-off gap between commands, so the flip-flop never sees S=R=1.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required before the debounced level changes; range 1..255.
- GAP_CYCLES, 2: idle cycles forced after each issued pulse; range 0..255.
- PRIO_SET, 0: collision winner; 0 = reset wins, 1 = set wins.
- CNT_W, 8: width of the debounce and gap counters; both counts must be < 2^CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_req  input  1  raw asynchronous set request, active high.
- rst_req  input  1  raw asynchronous reset request, active high.
- S  output  1  registered set pulse to the flip-flop.
- R  output  1  registered reset pulse to the flip-flop.
- busy  output  1  high while in ISSUE or HOLDOFF.
- collide  output  1  one-cycle pulse when a request was dropped by arbitration.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately.
  - S, R, busy and collide go to 0.
  - Synchroniser flops, debounced levels, counters and pending flags clear to 0; FSM goes to IDLE.
  - Reset asserted mid-pulse or mid-hold-off aborts everything; nothing is replayed after release.
- Synchroniser: two flops per request line.
- Debounce (per line):
  - Counter increments each cycle the synchroniser output differs from the debounced level and clears on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Event: a 0->1 transition of the debounced level is a one-cycle event. Falling edges are ignored.
- Pending flags set_pend / rst_pend:
  - Set on the cycle after the event.
  - Held until serviced or dropped.
  - A repeated event of the same type while pending is absorbed and not counted.
- FSM states:
  - IDLE:
    - If only one flag is pending, go to ISSUE with the matching output selected.
    - If both are pending, the winner per PRIO_SET is selected; the loser flag clears and collide pulses high for this cycle.
  - ISSUE: exactly one of S/R is high for exactly one cycle and the serviced flag clears. Next state is HOLDOFF, or IDLE if GAP_CYCLES = 0.
  - HOLDOFF: S=R=0 for GAP_CYCLES cycles, then IDLE. New events arriving here set pending flags and are serviced from IDLE.
- Latency: with the FSM idle and the raw line high and stable from clock edge 0, the pulse is high in the cycle following edge 2+DEBOUNCE_CYCLES+2. With the defaults, S is high after edge 8.
- Back-to-back commands: minimum spacing between two pulses is 1+GAP_CYCLES+1 cycles.
- Invariants, checked by assertions:
  - S & R never both 1.
  - S, R and collide are each never high for two consecutive cycles.
  - busy == (state != IDLE).
- Counter saturation does not occur by construction (parameter ranges above); widths are fixed at CNT_W bits, unsigned.

Decomposition:
- Shared package contains:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, HOLDOFF=2'd2.
  - PRIO_RESET/PRIO_SET constants.
  - Default DEBOUNCE_CYCLES/GAP_CYCLES values.
- One natural sub-module, sync_debounce: 2-flop synchroniser, debounce counter and rising-edge event output. It is instantiated once for set_req and once for rst_req.
- Pending flags, arbitration and the FSM live in the top level.

Test Plan:
- Reset then set_req held high from edge 0 (defaults) -> S=1 only in the cycle after edge 8, R stays 0, busy high for 3 cycles, collide 0.
- set_req pulses high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> no S/R pulse, busy never asserts.
- set_req and rst_req rise on the same edge, PRIO_SET=0 -> single R pulse, collide=1 one cycle, no S; repeat with PRIO_SET=1 -> single S pulse.
- rst_req event while in HOLDOFF after an S pulse -> R pulse issued exactly 1 cycle after HOLDOFF ends (S-to-R spacing 4 cycles at defaults).
- Deassert rst_n during the ISSUE cycle -> S drops immediately; after release with inputs low, no outputs for 20 cycles.
- GAP_CYCLES=0, set then reset events 10 cycles apart -> S pulse then R pulse, busy 1 cycle each, S&R never both 1.
